// File: rtl/pr_if_id_fifo_pkg.sv
// -----------------------------------------------------------------------------
// pr_if_id_fifo_pkg
// Shared types and defaults for the IF/ID fetch queue.
//   IF_ID_XLEN        : default data width of pc / pc4 / instr
//   IF_ID_FIFO_DEPTH  : default number of queue entries (power of 2, >= 2)
//   if_id_entry_t     : one queue entry {pc, pc4, instr} at the default width
//   mk_entry()        : builds an entry from a pc and instruction word
// -----------------------------------------------------------------------------
package pr_if_id_fifo_pkg;

    localparam int IF_ID_XLEN       = 32;
    localparam int IF_ID_FIFO_DEPTH = 4;

    typedef struct packed {
        logic [IF_ID_XLEN-1:0] pc;
        logic [IF_ID_XLEN-1:0] pc4;
        logic [IF_ID_XLEN-1:0] instr;
    } if_id_entry_t;

    function automatic if_id_entry_t mk_entry(input logic [IF_ID_XLEN-1:0] pc,
                                              input logic [IF_ID_XLEN-1:0] instr);
        if_id_entry_t e;
        e.pc    = pc;
        e.pc4   = pc + IF_ID_XLEN'(4);
        e.instr = instr;
        return e;
    endfunction

endpackage

// File: rtl/pr_if_id_fifo_if.sv
// -----------------------------------------------------------------------------
// pr_if_id_fifo_if
// Bundles the IF-side push bus, the ID-side head bus and the flush/stall
// controls of the fetch queue.
//   master : drives flush, stall and the IF fetch fields; observes ready,
//            head entry and occupancy
//   slave  : the queue itself (opposite directions)
// -----------------------------------------------------------------------------
interface pr_if_id_fifo_if
    import pr_if_id_fifo_pkg::*;
#(
    parameter int XLEN  = IF_ID_XLEN,
    parameter int DEPTH = IF_ID_FIFO_DEPTH
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             flush;
    logic             stall;
    logic [XLEN-1:0]  pc_if_i;
    logic [XLEN-1:0]  pc4_if_i;
    logic [XLEN-1:0]  instr_if_i;
    logic             instr_valid_if_i;
    logic             if_ready_o;
    logic [XLEN-1:0]  pc_id_o;
    logic [XLEN-1:0]  pc4_id_o;
    logic [XLEN-1:0]  instr_id_o;
    logic             instr_valid_id_o;
    logic [CNT_W-1:0] count_o;

    modport master (
        output flush, stall, pc_if_i, pc4_if_i, instr_if_i, instr_valid_if_i,
        input  if_ready_o, pc_id_o, pc4_id_o, instr_id_o, instr_valid_id_o, count_o
    );

    modport slave (
        input  flush, stall, pc_if_i, pc4_if_i, instr_if_i, instr_valid_if_i,
        output if_ready_o, pc_id_o, pc4_id_o, instr_id_o, instr_valid_id_o, count_o
    );

endinterface

// File: rtl/pr_fifo_core.sv
// -----------------------------------------------------------------------------
// pr_fifo_core
// Generic in-order FIFO: entry storage, read/write pointers and occupancy.
//   clk, rst_n : clock, asynchronous active-low reset (pointers/count only)
//   clr_i      : synchronous clear of pointers and count (highest priority)
//   push_i     : write wdata_i at the write pointer (caller guarantees !full)
//   pop_i      : advance the read pointer (caller guarantees !empty)
//   rdata_o    : head entry (raw storage, unmasked)
//   count_o    : occupancy 0..DEPTH
//   full_o     : count == DEPTH
//   empty_o    : count == 0
// -----------------------------------------------------------------------------
module pr_fifo_core #(
    parameter  int WIDTH = 96,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the wrap.
            if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing is visible until count says so.
    always_ff @(posedge clk) begin
        if (push_i && !clr_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    // Head is read asynchronously so a freshly pushed entry shows one edge
    // after the push, matching the old single-entry register timing.
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/pr_if_id_fifo.sv
// -----------------------------------------------------------------------------
// pr_if_id_fifo
// DEPTH-entry in-order fetch queue between IF and ID holding {pc, pc4, instr}.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus.flush  : drop every entry and any same-cycle push
//   bus.stall  : ID cannot accept; head entry is held
//   bus.*_if_i : IF fetch fields and valid; pushed when if_ready_o is high
//   bus.if_ready_o : queue not full (state only, independent of stall)
//   bus.*_id_o : head entry, forced to zero when the queue is empty
//   bus.count_o: occupancy 0..DEPTH
// -----------------------------------------------------------------------------
module pr_if_id_fifo
    import pr_if_id_fifo_pkg::*;
#(
    parameter  int XLEN  = IF_ID_XLEN,
    parameter  int DEPTH = IF_ID_FIFO_DEPTH,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    pr_if_id_fifo_if.slave    bus
);

    localparam int EW = 3 * XLEN;

    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [EW-1:0]    wdata;
    logic [EW-1:0]    rdata;
    logic [CNT_W-1:0] count;

    // Ready comes from the registered count only: a pop while full does not
    // open the door for a push in the same cycle.
    assign push  = bus.instr_valid_if_i & ~full & ~bus.flush;
    assign pop   = ~empty & ~bus.stall & ~bus.flush;
    assign wdata = {bus.pc_if_i, bus.pc4_if_i, bus.instr_if_i};

    pr_fifo_core #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (bus.flush),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wdata),
        .rdata_o (rdata),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    assign bus.if_ready_o       = ~full;
    assign bus.instr_valid_id_o = ~empty;
    assign bus.count_o          = count;

    // Mask so stale storage never leaks out of an empty queue.
    assign bus.pc_id_o    = empty ? '0 : rdata[EW-1 -: XLEN];
    assign bus.pc4_id_o   = empty ? '0 : rdata[2*XLEN-1 -: XLEN];
    assign bus.instr_id_o = empty ? '0 : rdata[XLEN-1:0];

endmodule

// File: doc/pr_if_id_fifo.md
Name: pr_if_id_fifo

Overview:
Parametrised successor to the single-entry IF/ID pipeline register. It is a DEPTH-entry in-order fetch queue between IF and ID, holding {pc, pc4, instr} per entry. IF keeps fetching while ID is stalled, until the queue fills. It keeps the existing flush/stall/valid semantics and adds backpressure to IF (if_ready_o) and an occupancy count.

Parameters:
XLEN, 32, width of pc, pc4 and instr fields
DEPTH, 4, number of entries; power of 2, >= 2
CNT_W, $clog2(DEPTH+1), width of count_o (derived; not overridden)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  discard all entries and any same-cycle push
stall  input  1  ID cannot accept; head entry is held
pc_if_i  input  XLEN  PC of fetched instruction
pc4_if_i  input  XLEN  PC+4 of fetched instruction
instr_if_i  input  XLEN  fetched instruction word
instr_valid_if_i  input  1  IF presents a valid instruction this cycle
if_ready_o  output  1  queue can accept a push this cycle
pc_id_o  output  XLEN  head entry PC
pc4_id_o  output  XLEN  head entry PC+4
instr_id_o  output  XLEN  head entry instruction
instr_valid_id_o  output  1  head entry valid (queue non-empty)
count_o  output  CNT_W  current occupancy, 0..DEPTH

Behaviour:
- Reset (rst_n low, asynchronous):
  - Pointers and count are cleared.
  - instr_valid_id_o=0, pc_id_o=pc4_id_o=instr_id_o=0, count_o=0, if_ready_o=1.
  - Storage contents are don't-care.
- Handshake:
  - push = instr_valid_if_i & if_ready_o & ~flush.
  - pop = instr_valid_id_o & ~stall & ~flush.
- if_ready_o = (count < DEPTH). It is registered-state only, with no combinational path from stall. When full, a same-cycle pop does not enable a push.
- Push:
  - Writes {pc, pc4, instr} at the write pointer.
  - Write pointer advances modulo DEPTH (natural wrap, power-of-2).
- Pop:
  - Read pointer advances modulo DEPTH.
- Count update:
  - count += push - pop.
  - Simultaneous push and pop leaves count unchanged and is legal at any non-full occupancy, including count=1.
- Latency:
  - A push into an empty queue appears on the *_id_o outputs after the next rising edge, i.e. the same one-cycle latency as the single-entry register.
  - No same-cycle bypass from IF inputs to ID outputs.
- Outputs:
  - *_id_o are driven from the head entry when count>0.
  - When count=0, pc/pc4/instr outputs read 0 and instr_valid_id_o=0. Outputs must never expose stale storage.
- Flush:
  - Has highest priority over push, pop and stall.
  - On the next edge: both pointers reset to 0, count=0, instr_valid_id_o=0.
  - A concurrent IF push is dropped.
- Stall with count>0: head and all outputs hold. Pushes continue until full.
- Stall with count=0: no effect. A push still occurs, so instr_valid_id_o=1 next cycle.
- Full (count=DEPTH): if_ready_o=0. IF must hold its inputs; the instruction is not lost.
- instr_valid_if_i=0 never pushes. Invalid instructions are not stored as bubbles.
- Reset asserted mid-operation: immediate clear as above; no partial state survives.

Decomposition:
- Shared package (include/defines.svh) holds:
  - typedef struct packed if_id_entry_t {pc, pc4, instr}, each XLEN wide.
  - localparam IF_ID_FIFO_DEPTH default constant.
- One sub-module, pr_fifo_core, is natural:
  - Holds generic entry storage, rd/wr pointers and count (parametrised on width and DEPTH).
  - Top level adds the flush/stall/valid mapping and the zero-when-empty output masking.

Test Plan:
1. Reset, then push pc=0x100, instr=0x00500093 with stall=0 -> next cycle instr_valid_id_o=1, pc_id_o=0x100, pc4_id_o=0x104, count_o=1. Following cycle, with no push, count_o=0 and outputs read 0.
2. stall=1, push 4 instrs at pc 0x200..0x20C (DEPTH=4) -> count_o=4, if_ready_o=0, pc_id_o=0x200 held. Release stall -> pops 0x200,0x204,0x208,0x20C on consecutive cycles, in order.
3. Full queue with valid IF input held at pc=0x210 -> not accepted while full. One pop -> if_ready_o=1 the next cycle, 0x210 accepted, and dequeued after 0x20C.
4. count_o=2, assert flush together with a valid push at pc=0x300 -> next cycle count_o=0, instr_valid_id_o=0, and 0x300 never appears on the outputs.
5. Continuous push and pop for 10 cycles, pc 0x400 + 4k -> count_o stays 1, outputs step through pc 0x400.. each cycle across pointer wrap, no drops or duplicates.
6. Assert rst_n=0 asynchronously, mid-cycle, with count_o=3 -> outputs go to 0 immediately, before the next clock edge. After release, if_ready_o=1 and count_o=0.
